// File: rtl/seq_stream_serializer.sv
// ---------------------------------------------------------------------------
// seq_stream_serializer
//
// Purpose:
//   Feeds the sequence detector's serial input. Parallel words of 1..WORD_W
//   bits are accepted over a valid/ready handshake, held in a small circular
//   FIFO and shifted out one bit per clock on out_seq. Consecutive words are
//   emitted back-to-back with no idle cycle, so the detector sees one
//   continuous bitstream across word boundaries.
//
// Configuration macro:
//   SER_MSB_FIRST_EN  - when defined, each word is emitted from bit [len-1]
//                       down to bit [0]. When undefined (default), bit [0]
//                       goes first. Timing and handshake are identical.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   producer offers in_data/in_len
//   in_ready    out  FIFO has room (transfer on in_valid && in_ready)
//   in_data     in   [WORD_W-1:0] payload, bits above the length ignored
//   in_len      in   [LEN_W-1:0] bit count, 0 encodes WORD_W
//   out_seq     out  serial bit to the detector
//   out_valid   out  out_seq carries a payload bit this cycle
//   word_done   out  pulse coinciding with the last bit of each word
//   busy        out  shifting or FIFO non-empty
//   fifo_level  out  [LVL_W-1:0] words held in the FIFO (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module seq_stream_serializer #(
    parameter int WORD_W     = 16,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out_seq,
    output logic              out_valid,
    output logic              word_done,
    output logic              busy,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int PTR_W = LVL_W - 1;
    localparam int ENT_W = WORD_W + LEN_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;

    // Serializer state
    state_t            state_reg;
    logic [WORD_W-1:0] shreg_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic              out_seq_reg;
    logic              out_valid_reg;
    logic              word_done_reg;

    // Datapath helpers
    logic [WORD_W-1:0] len_mask;
    logic [WORD_W-1:0] in_word;
    logic [ENT_W-1:0]  head;
    logic [WORD_W-1:0] head_data;
    logic [LEN_W-1:0]  head_len;
    logic [WORD_W-1:0] load_shreg;
    logic [LEN_W-1:0]  load_cnt;
    logic [WORD_W-1:0] shifted;
    logic              tap;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // Clear payload bits beyond the word length so the stored word is
    // exactly what will be emitted. in_len == 0 means a full-width word.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_len_mask
            assign len_mask[gi] = (in_len == '0) || (LEN_W'(gi) < in_len);
        end
    endgenerate

    assign in_word = in_data & len_mask;

    // The head entry is read combinationally: the last-bit edge must pop and
    // reload in the same cycle to keep consecutive words gap-free.
    assign head      = fifo_mem[rd_ptr_reg];
    assign head_data = head[WORD_W-1:0];
    assign head_len  = head[ENT_W-1:WORD_W];

    // Counter holds (bits remaining - 1). len == 0 wraps to WORD_W-1, which
    // is exactly the full-width count because WORD_W == 2**LEN_W.
    assign load_cnt = head_len - LEN_W'(1);

`ifdef SER_MSB_FIRST_EN
    // Left-align the word so bit [len-1] sits at the MSB tap. The shift
    // amount WORD_W-len reduces to (0 - len) mod WORD_W, which also yields
    // zero for the len == 0 (full-width) encoding.
    logic [LEN_W-1:0] msb_shift;
    assign msb_shift  = LEN_W'(0) - head_len;
    assign load_shreg = head_data << msb_shift;
    assign tap        = shreg_reg[WORD_W-1];
    assign shifted    = {shreg_reg[WORD_W-2:0], 1'b0};
`else
    assign load_shreg = head_data;
    assign tap        = shreg_reg[0];
    assign shifted    = {1'b0, shreg_reg[WORD_W-1:1]};
`endif

    assign fifo_empty = (level_reg == '0);
    assign in_ready   = (level_reg != LVL_W'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    // A new word is taken when idle, or on the last bit of the current word.
    assign pop        = !fifo_empty && ((state_reg == IDLE) || (cnt_reg == '0));

    // FIFO payload storage; contents need no reset since the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {in_len, in_word};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            cnt_reg       <= '0;
            out_seq_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            word_done_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                    out_seq_reg   <= 1'b0;
                    word_done_reg <= 1'b0;
                    if (pop) begin
                        shreg_reg <= load_shreg;
                        cnt_reg   <= load_cnt;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    out_valid_reg <= 1'b1;
                    out_seq_reg   <= tap;
                    word_done_reg <= (cnt_reg == '0);
                    if (cnt_reg == '0) begin
                        if (pop) begin
                            shreg_reg <= load_shreg;
                            cnt_reg   <= load_cnt;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        shreg_reg <= shifted;
                        cnt_reg   <= cnt_reg - LEN_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_seq    = out_seq_reg;
    assign out_valid  = out_valid_reg;
    assign word_done  = word_done_reg;
    assign busy       = (state_reg == SHIFT) || !fifo_empty;
    assign fifo_level = level_reg;

endmodule

// File: doc/seq_stream_serializer.md
Name: seq_stream_serializer

Overview:
Upstream feeder for the sequence detector. Accepts parallel words of 1..WORD_W bits over a valid/ready handshake and buffers them in a small FIFO. Emits the words one bit per clk on out_seq, which drives the detector's serial input directly. Back-to-back words stream with no gap cycles, so the detector sees a continuous bitstream across word boundaries.

Parameters:
WORD_W, 16, maximum word width in bits; must be a power of two, >= 2.
LEN_W, 4, width of in_len; equals log2(WORD_W).
FIFO_DEPTH, 4, word FIFO entries; must be a power of two, >= 2.
LVL_W, 3, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer offers in_data/in_len this cycle.
in_ready  output  1  FIFO can accept a word; transfer occurs when in_valid && in_ready at the clk edge.
in_data  input  WORD_W  word payload; bits above the word length are ignored.
in_len  input  LEN_W  number of bits to emit; 0 encodes WORD_W, 1..WORD_W-1 emit that many bits.
out_seq  output  1  serial bit to the detector.
out_valid  output  1  out_seq carries a payload bit this cycle.
word_done  output  1  one-cycle pulse coinciding with the last bit of each word.
busy  output  1  high when in SHIFT or FIFO non-empty.
fifo_level  output  LVL_W  number of words held in the FIFO (0..FIFO_DEPTH).

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO pointers and level = 0, state = IDLE, shift register = 0, bit counter = 0. Outputs: out_seq = 0, out_valid = 0, word_done = 0, busy = 0, fifo_level = 0, in_ready = 1 on the first cycle after reset release. Assertion mid-word drops the word and all FIFO contents immediately.
- FIFO: circular buffer of {in_data, in_len}. in_ready = (fifo_level != FIFO_DEPTH), derived combinationally from the registered level. A push on a full FIFO is impossible by construction. A push and pop in the same cycle leave fifo_level unchanged. A pop on an empty FIFO never occurs. Pointers wrap modulo FIFO_DEPTH.
- State machine, 2 states:
  - IDLE: out_valid = 0, out_seq = 0. If the FIFO is non-empty: pop the head, load the shift register and bit counter = effective length - 1, then go to SHIFT. The first bit appears on the next cycle. Latency from the accepting edge of an empty FIFO to the first out_valid is 2 cycles.
  - SHIFT: out_valid = 1 and out_seq = shift_reg[0], both registered. Each cycle, shift right by 1 and decrement the counter.
  - Last bit of a word (counter = 0): word_done = 1. If the FIFO is non-empty, pop and reload in the same edge and stay in SHIFT, giving zero bubble. Otherwise go to IDLE.
- Effective length: in_len = 0 means WORD_W. A 1-bit word produces a single out_valid cycle with word_done = 1.
- Underflow between words is not an error: out_valid drops and out_seq is forced to 0 until the next word.
- busy = (state == SHIFT) || (fifo_level != 0).

Optional Feature:
SER_MSB_FIRST_EN: when defined, each word is emitted starting at bit [len-1] and ending at bit [0]. The shift register is loaded left-aligned and shifts left, and out_seq taps the MSB. When undefined (default), words are emitted LSB first, bit [0] first. Timing, handshake and word_done behaviour are identical in both modes.

Test Plan:
- Reset, then push 16'b0110010010011010 with len = 0: out_valid goes high 2 cycles later and out_seq = 0,1,0,1,1,0,0,1,0,0,1,0,0,1,1,0 over 16 cycles. word_done pulses on the 16th bit, then out_valid = 0 and busy = 0.
- Push 4'b1011 (len = 4) and 3'b010 (len = 3) back-to-back: 7 contiguous out_valid cycles, out_seq = 1,1,0,1,0,1,0. word_done pulses on cycles 4 and 7, with no gap between words.
- Hold in_valid high with len = 0 words while the serializer streams: fifo_level reaches 4 and in_ready = 0. in_ready returns to 1 on the cycle after each pop. No word is lost or duplicated; check against a scoreboard.
- 1-bit words: push data = 1 (len = 1) three times: out_seq = 1,1,1 with word_done high on all three cycles.
- Assert rst_n low at bit 7 of a 16-bit word with 2 words queued: out_valid = 0, fifo_level = 0 and in_ready = 1 immediately and after release. No residual bits are emitted.
- With SER_MSB_FIRST_EN, push 16'b0110010010011010 (len = 0): out_seq = 0,1,1,0,0,1,0,0,1,0,0,1,1,0,1,0.
